// File: rtl/vend_pkg.sv
// Shared types and coin encodings for the vending controller slice.
package vend_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CREDIT   = 2'd1,
      S_DISPENSE = 2'd2,
      S_CHANGE   = 2'd3
   } vend_state_e;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   localparam logic [1:0] UNITS_5   = 2'd1;
   localparam logic [1:0] UNITS_10  = 2'd2;

   // Credit units carried by a coin pulse; 00/11 carry nothing.
   function automatic logic [1:0] coin_units(input logic [1:0] c);
      case (c)
         COIN_5:  coin_units = UNITS_5;
         COIN_10: coin_units = UNITS_10;
         default: coin_units = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_price_table.sv
// Per-item price register file: synchronous write, combinational read.
module vend_price_table #(
   parameter int NUM_ITEMS     = 4,
   parameter int CREDIT_W      = 4,
   parameter int DEFAULT_PRICE = 3,
   localparam int IDW          = $clog2(NUM_ITEMS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [IDW-1:0]      waddr,
   input  logic [CREDIT_W-1:0] wdata,
   input  logic [IDW-1:0]      raddr,
   output logic [CREDIT_W-1:0] rdata
);

   logic [NUM_ITEMS-1:0][CREDIT_W-1:0] price_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ITEMS; i++)
            price_q[i] <= CREDIT_W'(DEFAULT_PRICE);
      end else if (we) begin
         price_q[waddr] <= wdata;
      end
   end

   assign rdata = price_q[raddr];

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, priced selection, dispense and
// coin-by-coin change handshakes, with cancel and idle-timeout refund.
module vend_controller
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS     = 4,
   parameter int CREDIT_W      = 4,
   parameter int MAX_CREDIT    = 8,
   parameter int DEFAULT_PRICE = 3,
   parameter int TIMEOUT       = 255,
   localparam int IDW          = $clog2(NUM_ITEMS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          in,
   input  logic                sel_valid,
   input  logic [IDW-1:0]      sel_id,
   input  logic                cancel,
   input  logic                price_we,
   input  logic [IDW-1:0]      price_addr,
   input  logic [CREDIT_W-1:0] price_data,
   output logic                disp_req,
   output logic [IDW-1:0]      disp_id,
   input  logic                disp_ack,
   output logic                chg_req,
   output logic [1:0]          chg_coin,
   input  logic                chg_ack,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                busy
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   vend_state_e         state;
   logic [CREDIT_W-1:0] credit_q;
   logic [TMR_W-1:0]    tmr;
   logic [CREDIT_W-1:0] sel_price;

   logic [1:0]          coin_u;
   logic                coin_vld;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic                sel_ok;
   logic                cancel_ok;
   logic [CREDIT_W-1:0] chg_units;

   vend_price_table #(
      .NUM_ITEMS    (NUM_ITEMS),
      .CREDIT_W     (CREDIT_W),
      .DEFAULT_PRICE(DEFAULT_PRICE)
   ) u_price (
      .clk  (clk),
      .rst  (rst),
      .we   (price_we),
      .waddr(price_addr),
      .wdata(price_data),
      .raddr(sel_id),
      .rdata(sel_price)
   );

   always_comb begin
      coin_u    = coin_units(in);
      coin_vld  = (coin_u != 2'd0);
      coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_u);
      coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
      sel_ok    = (state == S_IDLE || state == S_CREDIT) && sel_valid &&
                  (sel_price != '0) && (credit_q >= sel_price);
      cancel_ok = (state == S_CREDIT) && cancel;
      chg_units = (credit_q >= CREDIT_W'(2)) ? CREDIT_W'(2) : CREDIT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         credit_q    <= '0;
         tmr         <= '0;
         disp_id     <= '0;
         coin_reject <= 1'b0;
      end else begin
         coin_reject <= 1'b0;
         case (state)
            S_IDLE, S_CREDIT: begin
               // A coin arriving with an accepted cancel/selection is refused.
               if (cancel_ok) begin
                  state       <= S_CHANGE;
                  tmr         <= '0;
                  coin_reject <= coin_vld;
               end else if (sel_ok) begin
                  credit_q    <= credit_q - sel_price;
                  disp_id     <= sel_id;
                  state       <= S_DISPENSE;
                  tmr         <= '0;
                  coin_reject <= coin_vld;
               end else if (coin_vld) begin
                  tmr <= '0;
                  if (coin_fits) begin
                     credit_q <= coin_sum[CREDIT_W-1:0];
                     state    <= S_CREDIT;
                  end else begin
                     coin_reject <= 1'b1;
                  end
               end else if (sel_valid) begin
                  tmr <= '0;
               end else if (state == S_CREDIT) begin
                  if (tmr >= TMR_W'(TIMEOUT - 1)) begin
                     state <= S_CHANGE;
                     tmr   <= '0;
                  end else begin
                     tmr <= tmr + 1'b1;
                  end
               end
            end
            S_DISPENSE: begin
               coin_reject <= coin_vld;
               tmr         <= '0;
               if (disp_ack)
                  state <= (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
               coin_reject <= coin_vld;
               tmr         <= '0;
               if (chg_ack) begin
                  credit_q <= credit_q - chg_units;
                  if (credit_q <= chg_units)
                     state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Handshake outputs decode straight from state/credit registers.
   assign disp_req = (state == S_DISPENSE);
   assign chg_req  = (state == S_CHANGE);
   assign busy     = disp_req | chg_req;
   assign chg_coin = chg_req ? ((credit_q >= CREDIT_W'(2)) ? COIN_10 : COIN_5)
                             : COIN_NONE;
   assign credit   = credit_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: hand-computed expectations per step.
module tb_vend_controller;

   localparam int TIMEOUT = 255;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] coin_in;
   logic       sel_valid;
   logic [1:0] sel_id;
   logic       cancel;
   logic       price_we;
   logic [1:0] price_addr;
   logic [3:0] price_data;
   logic       disp_req;
   logic [1:0] disp_id;
   logic       disp_ack;
   logic       chg_req;
   logic [1:0] chg_coin;
   logic       chg_ack;
   logic [3:0] credit;
   logic       coin_reject;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int n;

   vend_controller #(
      .NUM_ITEMS(4), .CREDIT_W(4), .MAX_CREDIT(8),
      .DEFAULT_PRICE(3), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .in(coin_in), .sel_valid(sel_valid),
      .sel_id(sel_id), .cancel(cancel), .price_we(price_we),
      .price_addr(price_addr), .price_data(price_data),
      .disp_req(disp_req), .disp_id(disp_id), .disp_ack(disp_ack),
      .chg_req(chg_req), .chg_coin(chg_coin), .chg_ack(chg_ack),
      .credit(credit), .coin_reject(coin_reject), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [1:0] c);
      coin_in = c;
      tick();
      coin_in = 2'b00;
   endtask

   initial begin
      rst = 1'b1; coin_in = 2'b00; sel_valid = 0; sel_id = 0; cancel = 0;
      price_we = 0; price_addr = 0; price_data = 0; disp_ack = 0; chg_ack = 0;
      tick(); tick();
      check("rst_credit", credit, 0);
      check("rst_disp_req", disp_req, 0);
      check("rst_chg_req", chg_req, 0);
      check("rst_chg_coin", chg_coin, 0);
      check("rst_busy", busy, 0);
      check("rst_reject", coin_reject, 0);
      rst = 1'b0;
      tick();

      // Exact price: 10 + 5, item 0, ack two cycles later
      coin(2'b10); check("t1_credit2", credit, 2);
      coin(2'b01); check("t1_credit3", credit, 3);
      sel_valid = 1; sel_id = 0; tick(); sel_valid = 0;
      check("t1_disp_req", disp_req, 1);
      check("t1_disp_id", disp_id, 0);
      check("t1_credit0", credit, 0);
      check("t1_busy", busy, 1);
      tick();
      check("t1_disp_hold", disp_req, 1);
      disp_ack = 1; tick(); disp_ack = 0;
      check("t1_disp_drop", disp_req, 0);
      check("t1_no_chg", chg_req, 0);
      check("t1_idle", busy, 0);

      // Overpay by one unit: dispense then one 5rs coin of change
      coin(2'b10); coin(2'b10); check("t2_credit4", credit, 4);
      sel_valid = 1; sel_id = 1; tick(); sel_valid = 0;
      check("t2_disp_id", disp_id, 1);
      check("t2_credit1", credit, 1);
      disp_ack = 1; tick(); disp_ack = 0;
      check("t2_chg_req", chg_req, 1);
      check("t2_chg_coin", chg_coin, 2'b01);
      chg_ack = 1; tick(); chg_ack = 0;
      check("t2_chg_done", chg_req, 0);
      check("t2_credit0", credit, 0);

      // Disabled item; coin alongside ignored selection still counts; cancel refund
      price_we = 1; price_addr = 2; price_data = 0; tick(); price_we = 0;
      coin(2'b10); check("t3_credit2", credit, 2);
      sel_valid = 1; sel_id = 2; coin_in = 2'b01; tick();
      sel_valid = 0; coin_in = 2'b00;
      check("t3_sel_ignored", disp_req, 0);
      check("t3_coin_counted", credit, 3);
      check("t3_no_reject", coin_reject, 0);
      cancel = 1; tick(); cancel = 0;
      check("t3_cancel_chg", chg_req, 1);
      check("t3_coin10", chg_coin, 2'b10);
      chg_ack = 1; tick();
      check("t3_credit1", credit, 1);
      check("t3_coin5", chg_coin, 2'b01);
      check("t3_chg_held", chg_req, 1);
      tick(); chg_ack = 0;
      check("t3_credit0", credit, 0);
      check("t3_idle", busy, 0);

      // Acks and cancel while idle are ignored
      chg_ack = 1; disp_ack = 1; cancel = 1; tick();
      chg_ack = 0; disp_ack = 0; cancel = 0;
      check("t3b_idle_busy", busy, 0);
      check("t3b_idle_credit", credit, 0);

      // Ceiling: 4 x 10rs then 5rs rejected; coin in DISPENSE rejected
      for (int i = 0; i < 4; i++) coin(2'b10);
      check("t4_credit8", credit, 8);
      check("t4_no_reject", coin_reject, 0);
      coin(2'b01);
      check("t4_reject", coin_reject, 1);
      check("t4_credit_hold", credit, 8);
      tick();
      check("t4_reject_pulse", coin_reject, 0);
      sel_valid = 1; sel_id = 3; tick(); sel_valid = 0;
      check("t4_credit5", credit, 5);
      coin(2'b10);
      check("t4_disp_reject", coin_reject, 1);
      check("t4_disp_credit", credit, 5);
      disp_ack = 1; tick(); disp_ack = 0;
      check("t4_chg_coin10", chg_coin, 2'b10);
      chg_ack = 1;
      tick(); check("t4_credit3", credit, 3);
      tick(); check("t4_credit1", credit, 1);
      check("t4_coin5", chg_coin, 2'b01);
      tick(); chg_ack = 0;
      check("t4_drained", credit, 0);
      check("t4_idle", chg_req, 0);

      // Timeout refund
      coin(2'b01);
      n = 0;
      while (!chg_req && n < 400) begin
         tick();
         n++;
      end
      check("t5_timeout_cycles", n, TIMEOUT);
      check("t5_chg_coin", chg_coin, 2'b01);
      chg_ack = 1; tick(); chg_ack = 0;
      check("t5_idle", busy, 0);
      check("t5_credit0", credit, 0);

      // Selection + coin same cycle; reset during change
      coin(2'b10); coin(2'b10);
      sel_valid = 1; sel_id = 0; coin_in = 2'b10; tick();
      sel_valid = 0; coin_in = 2'b00;
      check("t6_sel_reject", coin_reject, 1);
      check("t6_credit1", credit, 1);
      check("t6_disp_req", disp_req, 1);
      disp_ack = 1; tick(); disp_ack = 0;
      check("t6_chg_req", chg_req, 1);
      rst = 1; tick(); rst = 0;
      check("t6_rst_chg", chg_req, 0);
      check("t6_rst_credit", credit, 0);
      check("t6_rst_busy", busy, 0);
      coin(2'b10); coin(2'b10);
      sel_valid = 1; sel_id = 2; tick(); sel_valid = 0;
      check("t6_price_restored", disp_req, 1);
      check("t6_disp_id2", disp_id, 2);
      check("t6_credit_after", credit, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the coin-operated vending datapath. Accepts 5rs/10rs coin pulses and item selections, holds a programmable price table, accumulates credit, and drives two downstream resources over valid/ack handshakes: the item dispenser and the change hopper. Replaces the fixed single-price flow with multi-item pricing, cancel/timeout refund and coin-by-coin change payout.

## Interface
Parameters:
- NUM_ITEMS, 4: selectable items; sel_id/price_addr width = $clog2(NUM_ITEMS).
- CREDIT_W, 4: credit width, in 5rs units.
- MAX_CREDIT, 8: credit ceiling in units (40rs).
- DEFAULT_PRICE, 3: reset price of every item, in units (15rs).
- TIMEOUT, 255: idle cycles in CREDIT before auto-refund.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in  in  2  coin pulse: 01 = 5rs, 10 = 10rs, 00/11 = no coin; one pulse per coin.
- sel_valid  in  1  selection strobe.
- sel_id  in  IDW  selected item.
- cancel  in  1  refund request.
- price_we  in  1  price table write enable.
- price_addr  in  IDW  item to program.
- price_data  in  CREDIT_W  price in units; 0 = item disabled.
- disp_req  out  1  dispense request.
- disp_id  out  IDW  item to dispense, valid while disp_req.
- disp_ack  in  1  dispenser done.
- chg_req  out  1  change coin request.
- chg_coin  out  2  coin to pay: 01 = 5rs, 10 = 10rs.
- chg_ack  in  1  hopper paid coin.
- credit  out  CREDIT_W  current credit, units.
- coin_reject  out  1  one-cycle pulse: coin not accepted.
- busy  out  1  high in DISPENSE or CHANGE.

## Operation
- States: IDLE (credit 0), CREDIT, DISPENSE, CHANGE.
- IDLE/CREDIT, coin: credit += 1 (01) or 2 (10); state -> CREDIT. If credit + value > MAX_CREDIT: coin_reject, credit unchanged.
- Coin in DISPENSE or CHANGE: always rejected.
- Selection accepted when price[sel_id] != 0 and credit >= price: credit -= price, disp_id latched, -> DISPENSE. Otherwise ignored, state unchanged.
- cancel in CREDIT -> CHANGE; in IDLE, DISPENSE or CHANGE ignored.
- Priority in one cycle: cancel > accepted selection > coin. A coin coinciding with an accepted cancel/selection is rejected. A coin coinciding with an ignored selection is evaluated normally.
- Timeout counter clears on any coin, selection or state entry. When it reaches TIMEOUT in CREDIT -> CHANGE.
- DISPENSE: disp_req held with disp_id stable until disp_ack. On ack -> CHANGE if credit > 0, else IDLE.
- CHANGE: chg_req high; chg_coin = 10 if credit >= 2, else 01. On chg_ack: credit -= 2 or 1. Reaching 0 -> IDLE.
- Ack inputs are ignored while the matching req is low.
- Price writes are accepted in any state and affect the next cycle's comparison. They never alter an already-deducted credit.

## Timing
- Reset: state IDLE, credit 0, all prices DEFAULT_PRICE, timeout counter 0. All outputs 0.
- Reset mid-transaction drops disp_req/chg_req the next cycle and discards credit.
- Coin to credit update: 1 cycle (registered). coin_reject asserts the cycle after the offending coin, for exactly 1 cycle.
- Accepted selection: disp_req high the next cycle.
- disp_ack: disp_req low the next cycle. chg_req rises the next cycle if change is due.
- chg_req may stay high across consecutive coins. Each cycle with chg_req && chg_ack pays one coin. chg_coin and credit update the following cycle.
- Outputs are registered; no combinational input-to-output path.

## Structure
- Package vend_pkg: state enum, coin encodings (COIN_NONE/5/10), unit constants.
- Sub-module vend_price_table: NUM_ITEMS × CREDIT_W register file. Synchronous write, combinational read, reset to DEFAULT_PRICE.
- FSM, credit arithmetic and timeout counter live in vend_controller.

## Test plan
- Reset, then 10rs + 5rs, select item 0 (price 3), ack dispenser 2 cycles later -> disp_req/disp_id=0 until ack; credit 0; IDLE; no chg_req.
- 10rs + 10rs, select item 1 (price 3) -> dispense, then one chg_req with chg_coin=01; credit 1 -> 0.
- Program price[2]=0. Insert 10rs, select 2 -> ignored. Then cancel -> chg_coin=10 paid, IDLE.
- Insert 4 × 10rs (credit 8), add 5rs -> coin_reject pulse, credit stays 8. Coin during DISPENSE -> rejected.
- Insert 5rs, idle TIMEOUT cycles -> CHANGE, chg_coin=01, IDLE after ack.
- Same cycle: accepted selection + coin -> coin rejected. Assert rst while chg_req high -> chg_req low next cycle, credit 0, prices back to 3.
